// File: rtl/sram_march_bist_ctrl.sv
// sram_march_bist_ctrl: March C- built-in self-test sequencer for one 1RW SRAM macro.
// It walks six march elements over every address, checks each read and stops on the
// first mismatch. A progress/result byte is published for the board pads.
module sram_march_bist_ctrl #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 32,
  parameter int                READ_LAT = 1,
  parameter logic [DATA_W-1:0] BG_PAT   = {DATA_W{1'b0}}
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [2:0]        fail_elem_o,
  output logic [DATA_W-1:0] fail_data_o,
  output logic [7:0]        status_o,
  output logic              sram_csb_o,
  output logic              sram_web_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_din_o,
  input  logic [DATA_W-1:0] sram_dout_i
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OP   = 3'd1,
    ST_WAIT = 3'd2,
    ST_CHK  = 3'd3,
    ST_DONE = 3'd4,
    ST_FAIL = 3'd5
  } state_t;

  localparam logic [DATA_W-1:0] D0        = BG_PAT;
  localparam logic [DATA_W-1:0] D1        = ~BG_PAT;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  // Number of extra WAIT cycles minus one; CHK is always the last latency cycle.
  localparam logic [1:0]        WAIT_INIT = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

  // Element 0 only writes, element 5 only reads; the others read in phase 0, write in phase 1.
  function automatic logic op_is_read(input logic [2:0] elem, input logic phase);
    return (elem != 3'd0) && (phase == 1'b0);
  endfunction

  function automatic logic elem_is_down(input logic [2:0] elem);
    return (elem == 3'd3) || (elem == 3'd4);
  endfunction

  function automatic logic elem_last_phase(input logic [2:0] elem);
    return (elem == 3'd1) || (elem == 3'd2) || (elem == 3'd3) || (elem == 3'd4);
  endfunction

  function automatic logic [DATA_W-1:0] read_exp(input logic [2:0] elem);
    return ((elem == 3'd2) || (elem == 3'd4)) ? D1 : D0;
  endfunction

  function automatic logic [DATA_W-1:0] write_data(input logic [2:0] elem);
    return ((elem == 3'd1) || (elem == 3'd3)) ? D1 : D0;
  endfunction

  function automatic logic [7:0] status_code(input logic [2:0] elem);
    logic [7:0] code;
    case (elem)
      3'd0:    code = 8'h00;
      3'd1:    code = 8'h0A;
      3'd2:    code = 8'h14;
      3'd3:    code = 8'h1E;
      3'd4:    code = 8'h28;
      3'd5:    code = 8'h32;
      default: code = 8'h00;
    endcase
    return code;
  endfunction

  state_t              state_r, state_s;
  logic [2:0]          elem_r, elem_s;
  logic                phase_r, phase_s;
  logic [1:0]          wait_cnt_r, wait_cnt_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                pass_r, pass_s;
  logic [ADDR_W-1:0]   fail_addr_r, fail_addr_s;
  logic [2:0]          fail_elem_r, fail_elem_s;
  logic [DATA_W-1:0]   fail_data_r, fail_data_s;
  logic [7:0]          status_r, status_s;
  logic                csb_r, csb_s;
  logic                web_r, web_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [DATA_W-1:0]   din_r, din_s;

  logic                nx_end_s;
  logic [2:0]          nx_elem_s;
  logic [ADDR_W-1:0]   nx_addr_s;
  logic                nx_phase_s;
  logic                start_s;
  logic                advance_s;
  logic                issue_s;
  logic [2:0]          iss_elem_s;
  logic [ADDR_W-1:0]   iss_addr_s;
  logic                iss_phase_s;

  // Successor op in march order once the current op (write, or read plus check) completes.
  always_comb begin
    nx_end_s   = 1'b0;
    nx_elem_s  = elem_r;
    nx_addr_s  = addr_r;
    nx_phase_s = 1'b0;
    if (phase_r != elem_last_phase(elem_r)) begin
      nx_phase_s = 1'b1;
    end else if (addr_r != (elem_is_down(elem_r) ? ADDR_ZERO : ADDR_MAX)) begin
      nx_addr_s = elem_is_down(elem_r) ? (addr_r - ADDR_ONE) : (addr_r + ADDR_ONE);
    end else if (elem_r == 3'd5) begin
      nx_end_s = 1'b1;
    end else begin
      nx_elem_s = elem_r + 3'd1;
      nx_addr_s = elem_is_down(elem_r + 3'd1) ? ADDR_MAX : ADDR_ZERO;
    end
  end

  // Next-state and next-output decode; every output register is loaded from here.
  always_comb begin
    state_s     = state_r;
    elem_s      = elem_r;
    phase_s     = phase_r;
    wait_cnt_s  = wait_cnt_r;
    busy_s      = busy_r;
    done_s      = done_r;
    pass_s      = pass_r;
    fail_addr_s = fail_addr_r;
    fail_elem_s = fail_elem_r;
    fail_data_s = fail_data_r;
    status_s    = status_r;
    csb_s       = 1'b1;
    web_s       = 1'b1;
    addr_s      = addr_r;
    din_s       = din_r;
    start_s     = 1'b0;
    advance_s   = 1'b0;

    case (state_r)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start_i) begin
          start_s     = 1'b1;
          busy_s      = 1'b1;
          done_s      = 1'b0;
          pass_s      = 1'b0;
          fail_addr_s = ADDR_ZERO;
          fail_elem_s = 3'd0;
          fail_data_s = {DATA_W{1'b0}};
        end else begin
          state_s = state_r;
        end
      end
      ST_OP: begin
        if (op_is_read(elem_r, phase_r)) begin
          if (READ_LAT > 1) begin
            state_s    = ST_WAIT;
            wait_cnt_s = WAIT_INIT;
          end else begin
            state_s = ST_CHK;
          end
        end else begin
          advance_s = 1'b1;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r == 2'd0) begin
          state_s = ST_CHK;
        end else begin
          wait_cnt_s = wait_cnt_r - 2'd1;
        end
      end
      ST_CHK: begin
        if (sram_dout_i != read_exp(elem_r)) begin
          state_s     = ST_FAIL;
          busy_s      = 1'b0;
          done_s      = 1'b1;
          pass_s      = 1'b0;
          fail_addr_s = addr_r;
          fail_elem_s = elem_r;
          fail_data_s = sram_dout_i;
          status_s    = 8'hEE;
        end else begin
          advance_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // A new op is issued either by an accepted start or by completing the previous op.
    issue_s     = start_s || (advance_s && !nx_end_s);
    iss_elem_s  = start_s ? 3'd0 : nx_elem_s;
    iss_addr_s  = start_s ? ADDR_ZERO : nx_addr_s;
    iss_phase_s = start_s ? 1'b0 : nx_phase_s;

    if (advance_s && nx_end_s) begin
      state_s  = ST_DONE;
      busy_s   = 1'b0;
      done_s   = 1'b1;
      pass_s   = 1'b1;
      status_s = 8'hFF;
    end else if (issue_s) begin
      state_s  = ST_OP;
      elem_s   = iss_elem_s;
      phase_s  = iss_phase_s;
      addr_s   = iss_addr_s;
      csb_s    = 1'b0;
      web_s    = op_is_read(iss_elem_s, iss_phase_s);
      din_s    = op_is_read(iss_elem_s, iss_phase_s) ? din_r : write_data(iss_elem_s);
      status_s = status_code(iss_elem_s);
    end else begin
      csb_s = 1'b1;
    end
  end

  // State and output registers; reset aborts a run on the spot.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r     <= ST_IDLE;
      elem_r      <= 3'd0;
      phase_r     <= 1'b0;
      wait_cnt_r  <= 2'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      fail_addr_r <= ADDR_ZERO;
      fail_elem_r <= 3'd0;
      fail_data_r <= {DATA_W{1'b0}};
      status_r    <= 8'h00;
      csb_r       <= 1'b1;
      web_r       <= 1'b1;
      addr_r      <= ADDR_ZERO;
      din_r       <= {DATA_W{1'b0}};
    end else begin
      state_r     <= state_s;
      elem_r      <= elem_s;
      phase_r     <= phase_s;
      wait_cnt_r  <= wait_cnt_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      pass_r      <= pass_s;
      fail_addr_r <= fail_addr_s;
      fail_elem_r <= fail_elem_s;
      fail_data_r <= fail_data_s;
      status_r    <= status_s;
      csb_r       <= csb_s;
      web_r       <= web_s;
      addr_r      <= addr_s;
      din_r       <= din_s;
    end
  end

  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign pass_o      = pass_r;
  assign fail_addr_o = fail_addr_r;
  assign fail_elem_o = fail_elem_r;
  assign fail_data_o = fail_data_r;
  assign status_o    = status_r;
  assign sram_csb_o  = csb_r;
  assign sram_web_o  = web_r;
  assign sram_addr_o = addr_r;
  assign sram_din_o  = din_r;

endmodule
